nonogram_option_feeder: RTL
===========================

Name: nonogram_option_feeder

Overview:
- Circular option FIFO plus sequencer directly upstream of the nonogram solver.
- Accepts the generator's initial stream of line-index markers and candidate options, then replays it to the solver pass after pass.
- Each option is re-enqueued or dropped according to the solver's put-back verdict, and per-line option counts are kept current.
- Terminates when the solver reports solved, or when a full pass drops nothing (stuck/ambiguous).

Parameters:
- SIZE, 11, maximum board dimension; option word width.
- DEPTH, 1024, FIFO entries; power of two.
- CNT_W, 7, per-line option count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load word present.
- load_is_index  in  1  word is a line-index marker; index value is in load_data[4:0].
- load_data  in  SIZE  option bits, or line index.
- load_ready  out  1  feeder accepts load word.
- load_last  in  1  final load word; qualified by load_valid.
- started  out  1  first-pass pulse to solver.
- option  out  SIZE  word presented to solver.
- option_valid  out  1  option is valid.
- option_is_index  out  1  presented word is a line marker.
- result_valid  in  1  solver verdict for the current non-index option.
- put_back_to_fifo  in  1  keep option; qualified by result_valid.
- solved  in  1  solver board-solved flag.
- options_amnt  out  2*SIZE x CNT_W  live option count per line: rows 0..SIZE-1, cols SIZE..2*SIZE-1.
- pass_count  out  16  completed passes.
- done  out  1  sequencing finished; sticky.
- stuck  out  1  finished without solve; sticky.
- overflow  out  1  load exceeded DEPTH; sticky.

Behaviour:
- Reset values: all outputs 0; FIFO empty; options_amnt all 0; state IDLE. Reset mid-pass aborts immediately and discards the FIFO contents.
- Entry format: {is_index, data[SIZE-1:0]}. Head and tail pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.
- IDLE -> LOAD on the first load_valid.
- LOAD:
  - load_ready = !full.
  - A non-index word increments options_amnt[current line], saturating at 2^CNT_W-1.
  - An index word sets the current line.
  - load_valid while full sets overflow, enters DONE, and also sets stuck.
  - An accepted load_last -> PASS_START.
- PASS_START: latch pass_len = occupancy; clear the drop flag.
  - pass_len = 0 -> DONE with stuck = 1.
  - Otherwise -> FETCH.
- FETCH: read the head entry with 1-cycle read latency, pop it, decrement the remaining count -> PRESENT.
- PRESENT: option/option_is_index driven and option_valid high.
  - Index word: held exactly 1 cycle. Always re-pushed to the tail. Updates the current line. -> NEXT.
  - On the first index word of pass 0, started pulses for that same cycle only.
  - Non-index word: held until result_valid (result_valid in the same cycle as option_valid rise is legal).
    - put_back_to_fifo = 1: push to the tail.
    - put_back_to_fifo = 0: discard, decrement options_amnt[current line] (floor 0), set the drop flag.
    - -> NEXT.
- result_valid while presenting an index word, or while option_valid is low, is ignored.
- NEXT:
  - solved = 1 -> DONE (stuck = 0).
  - Remaining count > 0 -> FETCH.
  - Otherwise increment pass_count, then go to PASS_START if the drop flag is set, else DONE with stuck = 1.
- solved sampled high in any state after LOAD -> DONE at the next edge; an option in PRESENT is abandoned without push.
- FIFO never overflows after LOAD: each push is preceded by its pop. Pop and push in the same cycle keeps occupancy unchanged.
- DONE: option_valid = 0 and load_ready = 0; outputs hold until rst.
- Throughput: 2 cycles per index word; 2 cycles + solver wait per option.

Test Plan:
- 3x3 board, rows {3,3,1}, cols {1,3,3}; load idx0,100,010,001, idx1,100,010,001, idx2,000, idx3,000, idx4,100,010,001, idx5,100,010,001 → options_amnt[0..5] = 3,3,1,1,3,3; started pulses once, with option = 0 and option_is_index = 1.
- Same load; solver drops col2 opt 100 and col3 opt 100 in pass 0 → pass_count = 1, options_amnt[4] = options_amnt[5] = 2; pass 1 replays 20 − 2 = 18 words in the original order.
- Pass where the solver keeps every option → done = 1, stuck = 1, pass_count increments by one, no further option_valid.
- solved asserted during pass 1 mid-option → done = 1, stuck = 0 the next cycle; option_valid drops.
- DEPTH = 4 instance, load 5 words → load_ready low at 4 entries; a 5th load_valid sets overflow = done = stuck = 1.
- rst asserted during PRESENT → all outputs 0 next cycle; a fresh load of 2 words replays correctly.

Source files
------------

// File: rtl/nonogram_option_feeder.sv
// Circular option FIFO and pass sequencer feeding the nonogram solver.
// Loads the generator stream once, then replays it pass after pass, dropping rejected options.
module nonogram_line_cnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);
    // Saturates high, floors at zero; inc and dec never coincide.
    always_ff @(posedge clk) begin
        if (rst)                          count <= '0;
        else if (inc && count != '1)      count <= count + 1'b1;
        else if (dec && count != '0)      count <= count - 1'b1;
    end
endmodule

module nonogram_option_feeder #(
    parameter int SIZE  = 11,
    parameter int DEPTH = 1024,
    parameter int CNT_W = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_valid,
    input  logic                            load_is_index,
    input  logic [SIZE-1:0]                 load_data,
    output logic                            load_ready,
    input  logic                            load_last,
    output logic                            started,
    output logic [SIZE-1:0]                 option,
    output logic                            option_valid,
    output logic                            option_is_index,
    input  logic                            result_valid,
    input  logic                            put_back_to_fifo,
    input  logic                            solved,
    output logic [2*SIZE-1:0][CNT_W-1:0]    options_amnt,
    output logic [15:0]                     pass_count,
    output logic                            done,
    output logic                            stuck,
    output logic                            overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OW    = AW + 1;
    localparam int LINES = 2 * SIZE;

    typedef struct packed {
        logic            is_index;
        logic [SIZE-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PASS_START, S_FETCH, S_PRESENT, S_NEXT, S_DONE
    } state_t;

    state_t          state, state_nx;
    entry_t          mem [DEPTH];
    entry_t          cur, push_data;
    logic [AW-1:0]   head, tail;
    logic [OW-1:0]   occ, remaining;
    logic [4:0]      cur_line;
    logic            drop_flag, first_pending;
    logic            full, load_acc, pres_idx, verdict, abort;
    logic            push, pop, drop;
    logic            set_stuck, set_ovf, pass_inc;
    logic [LINES-1:0] inc_vec, dec_vec;

    assign full     = (occ == OW'(DEPTH));
    assign load_acc = (state == S_LOAD) && load_valid && !full;
    assign pres_idx = (state == S_PRESENT) && cur.is_index;
    assign verdict  = (state == S_PRESENT) && !cur.is_index && result_valid;
    assign abort    = solved && (state == S_PASS_START || state == S_FETCH ||
                                 state == S_PRESENT || state == S_NEXT);
    // NEXT doubles as the fetch cycle so each word costs two cycles plus solver wait.
    assign pop       = !abort && (state == S_FETCH || (state == S_NEXT && remaining != '0));
    assign push      = load_acc || (!abort && (pres_idx || (verdict && put_back_to_fifo)));
    assign drop      = !abort && verdict && !put_back_to_fifo;
    assign push_data = load_acc ? entry_t'({load_is_index, load_data}) : cur;

    assign load_ready      = (state == S_LOAD) && !full;
    assign option_valid    = (state == S_PRESENT);
    assign option          = (state == S_PRESENT) ? cur.data : '0;
    assign option_is_index = pres_idx;
    assign started         = pres_idx && first_pending && (pass_count == '0);
    assign done            = (state == S_DONE);

    always_comb begin
        state_nx  = state;
        set_stuck = 1'b0;
        set_ovf   = 1'b0;
        pass_inc  = 1'b0;
        case (state)
            S_IDLE: if (load_valid) state_nx = S_LOAD;
            S_LOAD: begin
                if (load_valid && full) begin
                    state_nx  = S_DONE;
                    set_ovf   = 1'b1;
                    set_stuck = 1'b1;
                end else if (load_acc && load_last) begin
                    state_nx = S_PASS_START;
                end
            end
            S_PASS_START: begin
                if (solved) state_nx = S_DONE;
                else if (occ == '0) begin
                    state_nx  = S_DONE;
                    set_stuck = 1'b1;
                end else state_nx = S_FETCH;
            end
            S_FETCH:   state_nx = solved ? S_DONE : S_PRESENT;
            S_PRESENT: begin
                if (solved) state_nx = S_DONE;
                else if (pres_idx || verdict) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (solved) state_nx = S_DONE;
                else if (remaining != '0) state_nx = S_PRESENT;
                else begin
                    pass_inc = 1'b1;
                    if (drop_flag) state_nx = S_PASS_START;
                    else begin
                        state_nx  = S_DONE;
                        set_stuck = 1'b1;
                    end
                end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            head          <= '0;
            tail          <= '0;
            occ           <= '0;
            remaining     <= '0;
            cur_line      <= '0;
            drop_flag     <= 1'b0;
            first_pending <= 1'b1;
            pass_count    <= '0;
            stuck         <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state <= state_nx;
            occ   <= occ + OW'(push) - OW'(pop);
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (state == S_PASS_START) remaining <= occ;
            else if (pop)              remaining <= remaining - 1'b1;
            if (state == S_PASS_START) drop_flag <= 1'b0;
            else if (drop)             drop_flag <= 1'b1;
            if (load_acc && load_is_index)  cur_line <= load_data[4:0];
            else if (pres_idx && !abort)    cur_line <= cur.data[4:0];
            if (started)   first_pending <= 1'b0;
            if (pass_inc)  pass_count <= pass_count + 1'b1;
            if (set_stuck) stuck <= 1'b1;
            if (set_ovf)   overflow <= 1'b1;
        end
    end

    // Storage carries no reset; the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
        if (pop)  cur <= mem[head];
    end

    for (genvar i = 0; i < LINES; i++) begin : g_line
        assign inc_vec[i] = load_acc && !load_is_index && (cur_line == 5'(i));
        assign dec_vec[i] = drop && (cur_line == 5'(i));
        nonogram_line_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[i]),
            .dec   (dec_vec[i]),
            .count (options_amnt[i])
        );
    end
endmodule
